stopwatch_counter: RTL and testbench
====================================

STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of synchronizer flops on tick_in (legal values 2..4).
REQ-002 clk_in  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 tick_in  input  1  divided clock from the clock divider output, asynchronous to clk_in.
REQ-005 start  input  1  level, sampled each cycle; requests RUN.
REQ-006 stop  input  1  level, sampled each cycle; requests PAUSE.
REQ-007 clear  input  1  level, sampled each cycle; requests IDLE with counts zeroed.
REQ-008 sec_ones  output  4  BCD seconds units, 0..9.
REQ-009 sec_tens  output  3  BCD seconds tens, 0..5.
REQ-010 min_ones  output  4  BCD minutes units, 0..9.
REQ-011 min_tens  output  3  BCD minutes tens, 0..5.
REQ-012 running  output  1  high while the state is RUN.
REQ-013 wrap  output  1  one-cycle pulse on the 59:59 -> 00:00 rollover.

Function
REQ-014 tick_in shall pass through a chain of SYNC_STAGES flops, then one edge-history flop; tick_edge = last sync stage AND NOT history flop.
REQ-015 Latency: with tick_in held high before clk_in edge k, the count increment shall be visible after edge k+SYNC_STAGES (after the 3rd edge with the default of 2).
REQ-016 Each tick_in high or low phase shall last at least 2 clk_in cycles to be counted exactly once; shorter phases may be missed, and a phase shall never be counted twice.
REQ-017 Divider pass-through mode (tick_in equal to clk_in) is unsupported; counting in that mode is undefined.
REQ-018 FSM states: IDLE, RUN, PAUSE.
REQ-019 IDLE: start goes to RUN; stop is ignored.
REQ-020 RUN: stop goes to PAUSE; start is ignored.
REQ-021 PAUSE: start goes to RUN; stop is ignored.
REQ-022 clear in any state shall go to IDLE and zero all four digits on the same edge.
REQ-023 Priority when inputs coincide: clear > stop > start.
REQ-024 Counting is qualified by the current (pre-edge) state: tick_edge increments only if the state is RUN.
REQ-025 A tick_edge coinciding with stop in RUN shall be counted.
REQ-026 A tick_edge coinciding with start in IDLE or PAUSE shall not be counted.
REQ-027 A tick_edge coinciding with clear shall be discarded; the counts go to zero.
REQ-028 Increment rule: sec_ones 9 -> 0 carries into sec_tens; sec_tens 5 -> 0 carries into min_ones; min_ones 9 -> 0 carries into min_tens; min_tens 5 -> 0 at 59:59 wraps to 00:00.
REQ-029 wrap shall be high exactly in the cycle after the 59:59 -> 00:00 update and low otherwise.
REQ-030 Digits shall hold their value in IDLE and PAUSE, and shall never leave the BCD ranges in REQ-008..011.
REQ-031 All outputs shall be driven directly from flops, with no combinational path from inputs to outputs.

Reset
REQ-032 On rst assertion, immediately and asynchronously: state IDLE, all digits 0, running 0, wrap 0, all synchronizer and history flops 0.
REQ-033 Reset asserted mid-count shall abort the count with no wrap pulse.
REQ-034 After rst deasserts, a tick_in already high shall produce one tick_edge; it shall be ignored unless the state is RUN.

Verification
REQ-035 Sync latency: reset, start, tick_in 0 -> 1 held 20 cycles -> sec_ones 0 -> 1 exactly 3 cycles after the rise; exactly one increment.
REQ-036 Carry chain: run 59 ticks -> 00:59; 1 more tick -> 01:00; total 3599 ticks -> 59:59; 1 more -> 00:00 with wrap high for exactly one cycle.
REQ-037 Pause and resume: 5 ticks, stop, 3 ticks, start, 2 ticks -> 00:07; running reads 1, 0, 1 across the phases.
REQ-038 Coincidence: clear+stop+start on one edge -> IDLE at 00:00; stop on the tick_edge cycle in RUN -> tick counted; start on the tick_edge cycle in PAUSE -> tick not counted.
REQ-039 Async reset: assert rst between clock edges at 12:34 -> outputs 00:00, running 0 before the next clk_in edge.
REQ-040 Glitch filter: 1-cycle tick_in high pulse -> at most one increment; random 2..50-cycle phases -> count equals the number of rising edges.

Source files
------------

// File: rtl/stopwatch_counter.sv
// MM:SS BCD stopwatch counting synchronized rising edges of an asynchronous tick.
// Latency: a tick_in rise before edge k updates the digits at edge k+SYNC_STAGES.
module stopwatch_counter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [3:0] sec_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [2:0] min_tens,
  output logic       running,
  output logic       wrap
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   tick_edge;

  logic [3:0] sec_ones_q, sec_ones_d;
  logic [2:0] sec_tens_q, sec_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [2:0] min_tens_q, min_tens_d;
  logic       running_q, running_d;
  logic       wrap_q, wrap_d;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick_edge = sync_q[SYNC_STAGES-1] & ~hist_q;

  // clear beats everything; stop only acts in RUN, start only outside RUN
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = RUN;
        RUN:     if (stop)  state_d = PAUSE;
        PAUSE:   if (start) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
    running_d = (state_d == RUN);
  end

  always_comb begin
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    wrap_d     = 1'b0;
    if (clear) begin
      sec_ones_d = 4'd0;
      sec_tens_d = 3'd0;
      min_ones_d = 4'd0;
      min_tens_d = 3'd0;
    end else if (tick_edge && (state_q == RUN)) begin
      if (sec_ones_q < 4'd9) begin
        sec_ones_d = sec_ones_q + 4'd1;
      end else begin
        sec_ones_d = 4'd0;
        if (sec_tens_q < 3'd5) begin
          sec_tens_d = sec_tens_q + 3'd1;
        end else begin
          sec_tens_d = 3'd0;
          if (min_ones_q < 4'd9) begin
            min_ones_d = min_ones_q + 4'd1;
          end else begin
            min_ones_d = 4'd0;
            if (min_tens_q < 3'd5) begin
              min_tens_d = min_tens_q + 3'd1;
            end else begin
              min_tens_d = 3'd0;
              wrap_d     = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sec_ones_q <= 4'd0;
      sec_tens_q <= 3'd0;
      min_ones_q <= 4'd0;
      min_tens_q <= 3'd0;
      running_q  <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_ones_q <= min_ones_d;
      min_tens_q <= min_tens_d;
      running_q  <= running_d;
      wrap_q     <= wrap_d;
    end
  end

  assign sec_ones = sec_ones_q;
  assign sec_tens = sec_tens_q;
  assign min_ones = min_ones_q;
  assign min_tens = min_tens_q;
  assign running  = running_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboard bench for stopwatch_counter: stimulus queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_stopwatch_counter;

  logic       clk_in;
  logic       rst;
  logic       tick_in;
  logic       start;
  logic       stop;
  logic       clear;
  logic [3:0] sec_ones;
  logic [2:0] sec_tens;
  logic [3:0] min_ones;
  logic [2:0] min_tens;
  logic       running;
  logic       wrap;

  typedef struct packed {
    logic [2:0] mt;
    logic [3:0] mo;
    logic [2:0] st;
    logic [3:0] so;
    logic       run;
    logic       wr;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    n_pass      = 0;
  int    n_total     = 0;
  int    wrap_cycles = 0;

  stopwatch_counter #(.SYNC_STAGES(2)) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .tick_in  (tick_in),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .min_ones (min_ones),
    .min_tens (min_tens),
    .running  (running),
    .wrap     (wrap)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic compare(input string nm, input obs_t got, input obs_t want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d%0d:%0d%0d run=%0b wrap=%0b, want %0d%0d:%0d%0d run=%0b wrap=%0b",
                  nm, got.mt, got.mo, got.st, got.so, got.run, got.wr,
                  want.mt, want.mo, want.st, want.so, want.run, want.wr);
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", nm, got, want);
  endtask

  task automatic exp_push(input string nm, input int mt, input int mo, input int st, input int so,
                          input logic run, input logic wr);
    obs_t e;
    e.mt  = mt[2:0];
    e.mo  = mo[3:0];
    e.st  = st[2:0];
    e.so  = so[3:0];
    e.run = run;
    e.wr  = wr;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: outputs are stable at the falling edge
  always @(negedge clk_in) begin
    obs_t cur;
    cur = {min_tens, min_ones, sec_tens, sec_ones, running, wrap};
    while (exp_q.size() != 0) compare(name_q.pop_front(), cur, exp_q.pop_front());
    if (wrap === 1'b1) wrap_cycles++;
  end

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; cyc(); clear = 1'b0;
  endtask

  // Each tick: 2 cycles high, 2 low; the count lands before the task returns.
  task automatic ticks(input int n);
    repeat (n) begin
      tick_in = 1'b1; cyc(); cyc();
      tick_in = 1'b0; cyc(); cyc();
    end
  endtask

  initial begin
    rst = 1'b1; tick_in = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
    cyc(); cyc();
    exp_push("reset", 0, 0, 0, 0, 1'b0, 1'b0);
    cyc(); rst = 1'b0;
    // tick_in already high at reset release: one edge, ignored in IDLE
    repeat (5) cyc();
    exp_push("post_rst_tick_idle", 0, 0, 0, 0, 1'b0, 1'b0);
    tick_in = 1'b0; repeat (3) cyc();

    // Sync latency: rise before edge P1, count visible after P3
    pulse_start();
    exp_push("start_run", 0, 0, 0, 0, 1'b1, 1'b0);
    tick_in = 1'b1; cyc();
    exp_push("lat_edge1", 0, 0, 0, 0, 1'b1, 1'b0);
    cyc();
    exp_push("lat_edge2", 0, 0, 0, 0, 1'b1, 1'b0);
    cyc();
    exp_push("lat_edge3", 0, 0, 0, 1, 1'b1, 1'b0);
    repeat (17) cyc();
    exp_push("lat_single_inc", 0, 0, 0, 1, 1'b1, 1'b0);
    tick_in = 1'b0; repeat (3) cyc();

    // Carry chain and wrap
    pulse_clear();
    exp_push("clear", 0, 0, 0, 0, 1'b0, 1'b0);
    pulse_start();
    ticks(59);
    exp_push("carry_00_59", 0, 0, 5, 9, 1'b1, 1'b0);
    ticks(1);
    exp_push("carry_01_00", 0, 1, 0, 0, 1'b1, 1'b0);
    ticks(3539);
    exp_push("carry_59_59", 5, 9, 5, 9, 1'b1, 1'b0);
    tick_in = 1'b1; cyc(); cyc();
    exp_push("pre_wrap", 5, 9, 5, 9, 1'b1, 1'b0);
    cyc();
    exp_push("wrap_high", 0, 0, 0, 0, 1'b1, 1'b1);
    tick_in = 1'b0; cyc();
    exp_push("wrap_low", 0, 0, 0, 0, 1'b1, 1'b0);
    cyc(); cyc();

    // Pause and resume
    pulse_clear();
    pulse_start();
    ticks(5);
    exp_push("pr_run5", 0, 0, 0, 5, 1'b1, 1'b0);
    pulse_stop();
    exp_push("pr_paused", 0, 0, 0, 5, 1'b0, 1'b0);
    ticks(3);
    exp_push("pr_hold", 0, 0, 0, 5, 1'b0, 1'b0);
    pulse_start();
    exp_push("pr_resume", 0, 0, 0, 5, 1'b1, 1'b0);
    ticks(2);
    exp_push("pr_final", 0, 0, 0, 7, 1'b1, 1'b0);

    // Coincidences
    clear = 1'b1; stop = 1'b1; start = 1'b1; cyc();
    clear = 1'b0; stop = 1'b0; start = 1'b0;
    exp_push("clr_stp_str", 0, 0, 0, 0, 1'b0, 1'b0);
    pulse_start();
    tick_in = 1'b1; cyc(); cyc();
    stop = 1'b1; cyc(); stop = 1'b0;
    exp_push("stop_on_edge", 0, 0, 0, 1, 1'b0, 1'b0);
    tick_in = 1'b0; cyc(); cyc();
    tick_in = 1'b1; cyc(); cyc();
    start = 1'b1; cyc(); start = 1'b0;
    exp_push("start_on_edge", 0, 0, 0, 1, 1'b1, 1'b0);
    tick_in = 1'b0; repeat (3) cyc();
    exp_push("no_late_count", 0, 0, 0, 1, 1'b1, 1'b0);
    tick_in = 1'b1; cyc(); cyc();
    clear = 1'b1; cyc(); clear = 1'b0;
    exp_push("clear_on_edge", 0, 0, 0, 0, 1'b0, 1'b0);
    tick_in = 1'b0; repeat (3) cyc();

    // Async reset between edges at 12:34
    pulse_start();
    ticks(754);
    exp_push("at_12_34", 1, 2, 3, 4, 1'b1, 1'b0);
    cyc();
    #1 rst = 1'b1;
    exp_push("async_rst", 0, 0, 0, 0, 1'b0, 1'b0);
    cyc(); rst = 1'b0; cyc();

    // Glitch filter: a one-cycle pulse still forms a single synchronized edge
    pulse_start();
    tick_in = 1'b1; cyc();
    tick_in = 1'b0; repeat (4) cyc();
    exp_push("one_cycle_pulse", 0, 0, 0, 1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick_in = 1'b1;
      repeat ($urandom_range(2, 50)) cyc();
      tick_in = 1'b0;
      repeat ($urandom_range(2, 50)) cyc();
    end
    repeat (4) cyc();
    exp_push("random_phases", 0, 0, 2, 1, 1'b1, 1'b0);

    repeat (3) cyc();
    check_int("queue_drained", exp_q.size(), 0);
    check_int("wrap_pulse_cycles", wrap_cycles, 1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
